i2s_initiator_sched: RTL and testbench
======================================

# i2s_initiator_sched

Frame scheduler and serializer for the I2S initiator transmit side. Generates `sck` and `ws` from the system clock and accepts one stereo frame per handshake, covering all `LANES` data lines. It shifts each frame onto `sd[LANES-1:0]` in Philips I2S format, so it directly drives an I2S target receiver. It also inserts silence and flags underrun when no frame is ready at a frame boundary.

## Interface
- `LANES`, 3, number of parallel `sd` lines.
- `DATA_W`, 16, bits per channel sample; legal range 2..32.
- `CLK_DIV`, 2, `clk` cycles per `sck` half-period; legal minimum 1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  run request; level-sensitive.
- `s_valid`  in  1  frame offered.
- `s_ready`  out  1  shadow register empty; frame accepted when `s_valid && s_ready`.
- `s_left`  in  LANES*DATA_W  left samples; lane i at bits [i*DATA_W +: DATA_W].
- `s_right`  in  LANES*DATA_W  right samples; same packing as `s_left`.
- `sck`  out  1  serial clock.
- `ws`  out  1  word select; 0 = left, 1 = right.
- `sd`  out  LANES  serial data, MSB first.
- `underrun`  out  1  one-`clk` pulse when a frame boundary finds the shadow register empty.
- `busy`  out  1  high in RUN and STOP.

## Operation
- Shadow register holds one frame plus a full flag.
  - `s_ready` = !full.
  - A handshake sets full.
  - A transfer into the shift register clears full.
  - When a transfer and a handshake fall in the same cycle, the register is refilled and full stays 1.
- Frame timing:
  - Slot counter `slot` runs 0..2*DATA_W-1 and wraps 2*DATA_W-1 -> 0.
  - Slot k carries left bit DATA_W-1-k for k < DATA_W, otherwise right bit 2*DATA_W-1-k.
  - `ws` = 1 for slots DATA_W-1..2*DATA_W-2, and 0 otherwise. It therefore leads the channel MSB by one slot.
- States:
  - IDLE -> RUN when `enable && full`. The shadow frame loads into the shift register, `slot` = 0, `sck` = 0, `sd` = left MSBs, `ws` = 0.
  - RUN: slots advance on every `sck` falling edge. At the 2*DATA_W-1 -> 0 wrap:
    - if full, load the shadow frame;
    - otherwise load all-zero data and pulse `underrun`.
  - RUN -> STOP when `enable` = 0, at any point in the frame.
  - STOP: the current frame completes. At the wrap, go to IDLE with no load and no underrun pulse.
  - STOP -> RUN when `enable` reasserts before the wrap; the wrap is then handled as in RUN.
- IDLE outputs: `sck` = 0, `ws` = 0, `sd` = 0, `busy` = 0. A pending full shadow frame is retained.
- `underrun` never asserts in IDLE or STOP.

## Timing
- Reset values: `sck` = 0, `ws` = 0, `sd` = 0, `underrun` = 0, `busy` = 0, `s_ready` = 1, full = 0, state IDLE.
- Reset has priority over every other event in the same cycle. Reset mid-frame aborts immediately, so the next cycle shows reset values and the shadow frame is discarded.
- `sck` half-period is exactly CLK_DIV `clk` cycles. The first rising edge comes CLK_DIV cycles after RUN entry.
- `sd` and `ws` change only in the same `clk` cycle that `sck` goes 1 -> 0. They hold stable across each rising edge.
- Frame length is 4*DATA_W*CLK_DIV `clk` cycles.
- Handshake latency:
  - An accept in IDLE with `enable` high gives RUN entry on the next cycle.
  - `s_ready` rises the cycle after the shadow-to-shift transfer.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `i2s_pkg`:
  - state enum `sched_state_t` {IDLE, RUN, STOP};
  - slot-counter width constant $clog2(2*DATA_W) as a function.
- Sub-module `i2s_sck_gen`:
  - `clk`/`rst_n`/`run` in; `sck`, `fall_stb`, `rise_stb` out;
  - `fall_stb` is a one-cycle pulse coincident with `sck` going low;
  - `run` = 0 resets the divide counter and forces `sck` = 0.
- Top level holds the shadow register, per-lane 2*DATA_W shift registers, slot counter and FSM.

## Test plan
All scenarios use LANES=3, DATA_W=16, CLK_DIV=2.
- Reset then idle, `enable` = 0 -> all outputs at reset values for 200 cycles; `s_ready` = 1.
- One frame: lane0 L=0xA5A5 R=0x5A5A, lane1 L=0xFFFF R=0x0000, lane2 L=0x8001 R=0x1234, `enable` = 1 -> per-lane bits on `sd` MSB-first over 32 slots; `ws` rises at slot 15 and falls at slot 31; `sck` period 4 cycles.
- Back-to-back frames with `s_valid` held and the next frame offered mid-frame -> no gap at the wrap; `underrun` never pulses; 128 cycles per frame.
- No second frame offered -> at the wrap, `underrun` pulses for exactly 1 cycle and the next frame is all zeros while `sck`/`ws` keep running.
- `enable` dropped at slot 5 -> frame completes to slot 31, then IDLE with `sck` = 0; a second test reasserts `enable` at slot 20 and the next frame follows without stopping.
- `rst_n` = 0 at slot 10 with the shadow full -> reset values on the next cycle; `s_ready` = 1; no output toggles until a new handshake.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and sizing helpers for the I2S initiator scheduler
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } sched_state_t;

  // Slot counter spans both channels of one frame.
  function automatic int slot_w(input int data_w);
    return $clog2(2 * data_w);
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// rtl/i2s_sck_gen.sv - serial clock divider with edge strobes for the I2S scheduler
module i2s_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          tick;

  // Strobes are high during the cycle whose closing edge flips sck, so the
  // scheduler can update sd/ws on exactly the edge that drops sck.
  always_comb begin
    tick  = run && (cnt_q == CNT_LAST);
    cnt_d = '0;
    sck_d = 1'b0;
    if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      sck_d = tick ? !sck_q : sck_q;
    end
  end

  assign fall_stb = tick && sck_q;
  assign rise_stb = tick && !sck_q;
  assign sck      = sck_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/i2s_initiator_sched.sv
// rtl/i2s_initiator_sched.sv - I2S transmit frame scheduler, shadow buffer and per-lane serializer
module i2s_initiator_sched
  import i2s_pkg::*;
#(
  parameter int LANES   = 3,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [LANES*DATA_W-1:0] s_left,
  input  logic [LANES*DATA_W-1:0] s_right,
  output logic                    sck,
  output logic                    ws,
  output logic [LANES-1:0]        sd,
  output logic                    underrun,
  output logic                    busy
);

  localparam int FW = 2 * DATA_W;
  localparam int SW = slot_w(DATA_W);
  localparam logic [SW-1:0] SLOT_LAST = SW'(FW - 1);
  localparam logic [SW-1:0] WS_FIRST  = SW'(DATA_W - 1);
  localparam logic [SW-1:0] WS_LAST   = SW'(FW - 2);

  sched_state_t state_q, state_d;
  logic                          full_q, full_d;
  logic [LANES*DATA_W-1:0]       sh_left_q, sh_left_d;
  logic [LANES*DATA_W-1:0]       sh_right_q, sh_right_d;
  logic [LANES-1:0][FW-1:0]      shift_q, shift_d;
  logic [LANES-1:0][FW-1:0]      shadow_frame;
  logic [SW-1:0]                 slot_q, slot_d, slot_inc;
  logic                          ws_q, ws_d;
  logic                          underrun_q, underrun_d;
  logic                          busy_q, busy_d;
  logic                          hs, xfer;
  logic                          fall_stb, rise_unused;

  i2s_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (state_q != IDLE),
    .sck      (sck),
    .fall_stb (fall_stb),
    .rise_stb (rise_unused)
  );

  // Each lane's shift word is left sample over right sample; sd is its MSB.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      shadow_frame[i] = {sh_left_q[i*DATA_W +: DATA_W], sh_right_q[i*DATA_W +: DATA_W]};
    end
  end

  always_comb begin
    hs         = s_valid && !full_q;
    xfer       = 1'b0;
    state_d    = state_q;
    slot_d     = slot_q;
    slot_inc   = slot_q + 1'b1;
    shift_d    = shift_q;
    ws_d       = ws_q;
    underrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && full_q) begin
          xfer    = 1'b1;
          state_d = RUN;
          slot_d  = '0;
          ws_d    = 1'b0;
          shift_d = shadow_frame;
        end
      end
      RUN, STOP: begin
        state_d = enable ? RUN : STOP;
        if (fall_stb) begin
          if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            ws_d   = 1'b0;
            if (!enable) begin
              // Stopping: the frame just finished, so fall back to silence.
              state_d = IDLE;
              shift_d = '0;
            end else if (full_q) begin
              xfer    = 1'b1;
              shift_d = shadow_frame;
            end else begin
              shift_d    = '0;
              underrun_d = 1'b1;
            end
          end else begin
            slot_d = slot_inc;
            ws_d   = (slot_inc >= WS_FIRST) && (slot_inc <= WS_LAST);
            for (int i = 0; i < LANES; i++) begin
              shift_d[i] = {shift_q[i][FW-2:0], 1'b0};
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
        ws_d    = 1'b0;
      end
    endcase

    full_d     = (full_q && !xfer) || hs;
    sh_left_d  = hs ? s_left  : sh_left_q;
    sh_right_d = hs ? s_right : sh_right_q;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      full_q     <= 1'b0;
      sh_left_q  <= '0;
      sh_right_q <= '0;
      shift_q    <= '0;
      slot_q     <= '0;
      ws_q       <= 1'b0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      sh_left_q  <= sh_left_d;
      sh_right_q <= sh_right_d;
      shift_q    <= shift_d;
      slot_q     <= slot_d;
      ws_q       <= ws_d;
      underrun_q <= underrun_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sd[i] = shift_q[i][FW-1];
    end
  end

  assign s_ready  = !full_q;
  assign ws       = ws_q;
  assign underrun = underrun_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2s_initiator_sched.sv
// tb/tb_i2s_initiator_sched.sv - scoreboard bench for the I2S initiator scheduler
module tb_i2s_initiator_sched;

  localparam int LANES   = 3;
  localparam int DATA_W  = 16;
  localparam int CLK_DIV = 2;
  localparam int FW      = 2 * DATA_W;
  localparam int SIG_UR    = 0;
  localparam int SIG_BUSY  = 1;
  localparam int SIG_READY = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic s_valid = 1'b0;
  logic [LANES*DATA_W-1:0] s_left = '0;
  logic [LANES*DATA_W-1:0] s_right = '0;
  logic s_ready, sck, ws, underrun, busy;
  logic [LANES-1:0] sd;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int underrun_total = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_initiator_sched #(
    .LANES   (LANES),
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_left   (s_left),
    .s_right  (s_right),
    .sck      (sck),
    .ws       (ws),
    .sd       (sd),
    .underrun (underrun),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected {ws, sd[2:0]} for each slot, from the Philips framing rules.
  task automatic push_frame(input logic [47:0] l, input logic [47:0] r, input int nslots);
    for (int k = 0; k < nslots; k++) begin
      logic [3:0] e;
      e[3] = (k >= DATA_W - 1) && (k <= 2 * DATA_W - 2);
      for (int i = 0; i < LANES; i++) begin
        if (k < DATA_W) e[i] = l[i*DATA_W + DATA_W - 1 - k];
        else            e[i] = r[i*DATA_W + 2*DATA_W - 1 - k];
      end
      exp_q.push_back(e);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      SIG_UR:    sig = underrun;
      SIG_BUSY:  sig = busy;
      SIG_READY: sig = s_ready;
      default:   sig = 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int w, input logic v, input int budget, input string nm);
    int c = 0;
    while (sig(w) !== v && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(nm, sig(w), v);
  endtask

  task automatic wait_falls(input int n, input string nm);
    int seen = 0;
    logic p;
    p = sck;
    for (int c = 0; c < 4000 && seen < n; c++) begin
      @(negedge clk);
      if (p && !sck) seen++;
      p = sck;
    end
    chk(nm, seen, n);
  endtask

  task automatic offer(input logic [47:0] l, input logic [47:0] r, input string nm);
    logic acc = 1'b0;
    int c = 0;
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    while (!acc && c < 1000) begin
      acc = s_ready;
      @(negedge clk);
      c++;
    end
    s_valid = 1'b0;
    chk(nm, acc, 1'b1);
  endtask

  // Monitor: every sck rising edge presents one slot to the receiver.
  logic sck_p = 1'b0;
  logic ur_p = 1'b0;
  logic [3:0] out_p = '0;
  logic [3:0] mon_e;
  int last_rise = -1;

  always @(negedge clk) begin
    if (sck && !sck_p) begin
      chk("sd_ws_stable_at_rise", {ws, sd}, out_p);
      chk("slot_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("slot_data", {ws, sd}, mon_e);
      end
      if (last_rise >= 0) chk("sck_period", cyc - last_rise, 2 * CLK_DIV);
      last_rise = cyc;
    end
    if (!busy) last_rise = -1;
    if (underrun) begin
      underrun_total++;
      chk("underrun_width", ur_p, 1'b0);
    end
    sck_p = sck;
    ur_p  = underrun;
    out_p = {ws, sd};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  localparam logic [47:0] F1L = {16'h8001, 16'hFFFF, 16'hA5A5};
  localparam logic [47:0] F1R = {16'h1234, 16'h0000, 16'h5A5A};
  localparam logic [47:0] F2L = {16'hC3C3, 16'h0F0F, 16'h8000};
  localparam logic [47:0] F2R = {16'h0001, 16'hF0F0, 16'h7FFF};
  localparam logic [47:0] F3L = {16'h1357, 16'h2468, 16'hDEAD};
  localparam logic [47:0] F3R = {16'hBEEF, 16'hCAFE, 16'h0F1E};
  localparam logic [47:0] F4L = {16'hFFFF, 16'hAAAA, 16'h5555};
  localparam logic [47:0] F4R = {16'h0000, 16'h5555, 16'hAAAA};
  localparam logic [47:0] F5L = {16'h9999, 16'h6666, 16'h3333};
  localparam logic [47:0] F5R = {16'h1111, 16'h2222, 16'h4444};

  initial begin
    int base_ur;
    int t0;
    int t1;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle_outputs", {sck, ws, sd, underrun, busy, s_ready}, 8'h01);
    end

    // Single frame, then underrun frame of zeros, stop requested at slot 5.
    push_frame(F1L, F1R, FW);
    push_frame('0, '0, FW);
    base_ur = underrun_total;
    enable = 1'b1;
    offer(F1L, F1R, "handshake_f1");
    wait_sig(SIG_UR, 1'b1, 400, "underrun_seen");
    @(negedge clk);
    chk("underrun_one_cycle", underrun, 1'b0);
    wait_falls(5, "reach_slot5_zero_frame");
    enable = 1'b0;
    wait_sig(SIG_BUSY, 1'b0, 400, "stop_to_idle");
    chk("idle_after_stop", {sck, ws, sd}, 5'b0);
    chk("underruns_single_frame", underrun_total - base_ur, 1);
    chk("queue_drained_b", exp_q.size(), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_sck_low", {sck, busy}, 2'b00);
    end

    // Back-to-back frames with a STOP->RUN recovery inside the first.
    push_frame(F2L, F2R, FW);
    push_frame(F3L, F3R, FW);
    base_ur = underrun_total;
    enable = 1'b1;
    offer(F2L, F2R, "handshake_f2");
    wait_sig(SIG_BUSY, 1'b1, 10, "run_entry_f2");
    t0 = cyc;
    wait_falls(8, "reach_slot8_f2");
    offer(F3L, F3R, "handshake_f3");
    wait_falls(2, "reach_slot10_f2");
    enable = 1'b0;
    wait_falls(10, "reach_slot20_f2");
    chk("busy_in_stop", busy, 1'b1);
    enable = 1'b1;
    wait_sig(SIG_READY, 1'b1, 200, "f3_loaded");
    t1 = cyc;
    chk("frame_length", t1 - t0, 4 * DATA_W * CLK_DIV);
    wait_falls(5, "reach_slot5_f3");
    enable = 1'b0;
    wait_sig(SIG_BUSY, 1'b0, 400, "stop_to_idle_f3");
    chk("underruns_back_to_back", underrun_total - base_ur, 0);
    chk("queue_drained_c", exp_q.size(), 0);

    // Reset at slot 10 with the shadow holding a pending frame.
    push_frame(F4L, F4R, 10);
    enable = 1'b1;
    offer(F4L, F4R, "handshake_f4");
    wait_sig(SIG_BUSY, 1'b1, 10, "run_entry_f4");
    wait_falls(3, "reach_slot3_f4");
    offer(F5L, F5R, "handshake_f5");
    chk("shadow_full", s_ready, 1'b0);
    wait_falls(7, "reach_slot10_f4");
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_frame", {sck, ws, sd, underrun, busy, s_ready}, 8'h01);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("quiet_after_reset", {sck, ws, sd, underrun, busy, s_ready}, 8'h01);
    end
    enable = 1'b0;
    chk("queue_drained_d", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
